proc_load_ctrl: RTL and testbench

PROC_LOAD_CTRL -- requirements
Module: proc_load_ctrl

---
 rtl/proc_load_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_proc_load_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_load_ctrl.sv
// proc_load_ctrl
// Software-facing load/run controller for a small processor datapath.
// Software writes instruction words into instruction memory through a
// command/address/data register triple, then runs, pauses, single-steps and
// clears the datapath. All state changes on the rising edge of clk.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-low reset
//   sw_cmd       : command register; [0] load, [1] run, [2] step, [3] clr
//   sw_imem_addr : software instruction address
//   sw_imem_data : software instruction data
//   proc_halt    : datapath halt indication (level)
//   imem_we      : one-cycle instruction-memory write pulse
//   imem_addr    : instruction-memory write address (held between pulses)
//   imem_wdata   : instruction-memory write data (held between pulses)
//   proc_hold    : high holds the datapath in reset
//   proc_en      : high advances the datapath one cycle per clk
//   status       : [2:0] state, [3] proc_halt, [15:4] write count,
//                  [31:16] enabled-cycle count (or zero)
//
// Build option
//   PROC_LOAD_CTRL_CYCLE_CNT_EN : when defined, a saturating 16-bit count of
//   proc_en cycles is kept and reported in status[31:16]; otherwise the
//   counter is absent and status[31:16] reads zero.
module proc_load_ctrl #(
    parameter int IMEM_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                sw_cmd,
    input  logic [31:0]                sw_imem_addr,
    input  logic [DATA_WIDTH-1:0]      sw_imem_data,
    input  logic                       proc_halt,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0]      imem_wdata,
    output logic                       proc_hold,
    output logic                       proc_en,
    output logic [31:0]                status
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        STEP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int CMD_LOAD = 0;
    localparam int CMD_RUN  = 1;
    localparam int CMD_STEP = 2;
    localparam int CMD_CLR  = 3;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state;
    state_t      state_next;
    logic [3:0]  cmd_q;
    logic [31:0] addr_prev;
    logic [11:0] write_cnt;
    logic        hold_d;
    logic        en_d;
    logic        wr_hit;
    logic        load_entry;
    logic        idle_entry;
    logic [15:0] status_hi;

    // Only the four command bits carry meaning.
    wire unused_cmd_bits = ^sw_cmd[31:4];

    wire cmd_load = sw_cmd[CMD_LOAD];
    wire cmd_run  = sw_cmd[CMD_RUN];
    wire rise_run  = sw_cmd[CMD_RUN]  & ~cmd_q[CMD_RUN];
    wire rise_step = sw_cmd[CMD_STEP] & ~cmd_q[CMD_STEP];
    wire rise_clr  = sw_cmd[CMD_CLR]  & ~cmd_q[CMD_CLR];

    // Next state and next registered outputs. Checks are ordered so that
    // clr wins over halt, and halt wins over run/step.
    always_comb begin
        state_next = state;
        hold_d     = 1'b0;
        en_d       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_load)      state_next = LOAD;
                else if (rise_run) state_next = RUN;
            end
            LOAD: begin
                if (!cmd_load) state_next = IDLE;
            end
            RUN: begin
                if (rise_clr)       state_next = IDLE;
                else if (proc_halt) state_next = DONE;
                else if (!cmd_run)  state_next = PAUSE;
            end
            PAUSE: begin
                if (rise_clr)       state_next = IDLE;
                else if (rise_run)  state_next = RUN;
                else if (rise_step) state_next = STEP;
            end
            STEP: begin
                state_next = proc_halt ? DONE : PAUSE;
            end
            DONE: begin
                if (rise_clr) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Outputs follow the current state, so they land one edge after the
        // transition that produced it.
        hold_d = (state == IDLE) || (state == LOAD);
        en_d   = (state == RUN)  || (state == STEP);
    end

    // A write fires only on an address change seen while load is still held
    // in LOAD; an address change in the same cycle load drops is discarded.
    assign wr_hit     = (state == LOAD) && cmd_load && (sw_imem_addr != addr_prev);
    assign load_entry = (state_next == LOAD) && (state != LOAD);
    assign idle_entry = (state_next == IDLE) && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cmd_q      <= 4'd0;
            addr_prev  <= 32'hFFFF_FFFF;
            write_cnt  <= 12'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            proc_hold  <= 1'b1;
            proc_en    <= 1'b0;
        end else begin
            state     <= state_next;
            cmd_q     <= sw_cmd[3:0];
            addr_prev <= sw_imem_addr;
            proc_hold <= hold_d;
            proc_en   <= en_d;
            imem_we   <= wr_hit;
            if (wr_hit) begin
                imem_addr  <= sw_imem_addr[IMEM_ADDR_WIDTH-1:0];
                imem_wdata <= sw_imem_data;
            end
            if (load_entry)  write_cnt <= 12'd0;
            else if (wr_hit) write_cnt <= sat_inc12(write_cnt);
        end
    end

`ifdef PROC_LOAD_CTRL_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt <= 16'd0;
        end else if (idle_entry) begin
            cycle_cnt <= 16'd0;
        end else if (proc_en) begin
            cycle_cnt <= sat_inc16(cycle_cnt);
        end
    end

    assign status_hi = cycle_cnt;
`else
    wire unused_idle_entry = idle_entry;
    assign status_hi = 16'd0;
`endif

    assign status = {status_hi, write_cnt, proc_halt, state};

endmodule

// File: tb/tb_proc_load_ctrl.sv
module tb_proc_load_ctrl;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   sw_cmd;
    logic [31:0]   sw_imem_addr;
    logic [DW-1:0] sw_imem_data;
    logic          proc_halt;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          proc_hold;
    logic          proc_en;
    logic [31:0]   status;

    proc_load_ctrl #(.IMEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_cmd       (sw_cmd),
        .sw_imem_addr (sw_imem_addr),
        .sw_imem_data (sw_imem_data),
        .proc_halt    (proc_halt),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .proc_hold    (proc_hold),
        .proc_en      (proc_en),
        .status       (status)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: controller mode as a plain integer plus the
    // externally visible quantities.
    int            m_mode;
    logic [3:0]    m_cmd_prev;
    logic [31:0]   m_addr_prev;
    int            m_wcnt;
    int            m_ccnt;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_hold;
    logic          m_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int  nxt;
        bit  ld, rn, r_run, r_step, r_clr, wr;
        if (!reset) begin
            m_mode = 0; m_cmd_prev = 4'h0; m_addr_prev = 32'hFFFF_FFFF;
            m_wcnt = 0; m_ccnt = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_hold = 1; m_en = 0;
            return;
        end
        ld     = sw_cmd[0];
        rn     = sw_cmd[1];
        r_run  = sw_cmd[1] && !m_cmd_prev[1];
        r_step = sw_cmd[2] && !m_cmd_prev[2];
        r_clr  = sw_cmd[3] && !m_cmd_prev[3];
        nxt = m_mode;
        if (m_mode == 0)      nxt = ld ? 1 : (r_run ? 2 : 0);
        else if (m_mode == 1) nxt = ld ? 1 : 0;
        else if (m_mode == 2) nxt = r_clr ? 0 : (proc_halt ? 5 : (!rn ? 3 : 2));
        else if (m_mode == 3) nxt = r_clr ? 0 : (r_run ? 2 : (r_step ? 4 : 3));
        else if (m_mode == 4) nxt = proc_halt ? 5 : 3;
        else if (m_mode == 5) nxt = r_clr ? 0 : 5;

        wr = (m_mode == 1) && ld && (sw_imem_addr != m_addr_prev);
        m_we = wr;
        if (wr) begin
            m_addr  = sw_imem_addr[AW-1:0];
            m_wdata = sw_imem_data;
            if (m_wcnt < 4095) m_wcnt++;
        end
        if (nxt == 1 && m_mode != 1) m_wcnt = 0;

        if (nxt == 0 && m_mode != 0) m_ccnt = 0;
        else if (m_en && m_ccnt < 65535) m_ccnt++;

        m_hold      = (m_mode == 0 || m_mode == 1);
        m_en        = (m_mode == 2 || m_mode == 4);
        m_addr_prev = sw_imem_addr;
        m_cmd_prev  = sw_cmd[3:0];
        m_mode      = nxt;
    endtask

    function automatic logic [31:0] exp_status();
        logic [15:0] hi;
`ifdef PROC_LOAD_CTRL_CYCLE_CNT_EN
        hi = 16'(m_ccnt);
`else
        hi = 16'd0;
`endif
        return {hi, 12'(m_wcnt), proc_halt, 3'(m_mode)};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("status",     status,              exp_status());
        check("imem_we",    32'(imem_we),        32'(m_we));
        check("imem_addr",  32'(imem_addr),      32'(m_addr));
        check("imem_wdata", imem_wdata,          m_wdata);
        check("proc_hold",  32'(proc_hold),      32'(m_hold));
        check("proc_en",    32'(proc_en),        32'(m_en));
    endtask

    initial begin
        reset        = 1'b0;
        sw_cmd       = 32'd0;
        sw_imem_addr = 32'hFFFF_FFFF;
        sw_imem_data = '0;
        proc_halt    = 1'b0;

        // Reset held two cycles, then released.
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_status", status, 32'h0000_0000);
        check("rst_hold",   32'(proc_hold), 32'd1);
        check("rst_en",     32'(proc_en),   32'd0);
        check("rst_we",     32'(imem_we),   32'd0);

        // Load two words.
        sw_cmd = 32'h1;
        tick();
        check("load_state", 32'(status[2:0]), 32'd1);
        sw_imem_addr = 32'd0; sw_imem_data = 32'hDEAD_BEEF;
        tick();
        check("wr0_we",   32'(imem_we),   32'd1);
        check("wr0_addr", 32'(imem_addr), 32'd0);
        check("wr0_data", imem_wdata,     32'hDEAD_BEEF);
        tick();
        check("gap_we", 32'(imem_we), 32'd0);
        sw_imem_addr = 32'd1; sw_imem_data = 32'h1234_5678;
        tick();
        check("wr1_we",   32'(imem_we),   32'd1);
        check("wr1_addr", 32'(imem_addr), 32'd1);
        check("wr1_data", imem_wdata,     32'h1234_5678);
        tick();
        check("wr1_once", 32'(imem_we), 32'd0);
        check("wcnt2",    32'(status[15:4]), 32'd2);

        // Address change coincides with load falling: no write.
        sw_cmd = 32'h0; sw_imem_addr = 32'd2; sw_imem_data = 32'hCAFE_0002;
        tick();
        check("drop_we",    32'(imem_we),        32'd0);
        check("drop_state", 32'(status[2:0]),    32'd0);
        check("drop_hold",  32'(imem_addr),      32'd1);

        // Run for ten cycles, then halt.
        sw_cmd = 32'h2;
        tick();
        check("run_state", 32'(status[2:0]), 32'd2);
        tick();
        check("run_hold", 32'(proc_hold), 32'd0);
        check("run_en",   32'(proc_en),   32'd1);
        for (int i = 0; i < 8; i++) tick();
        proc_halt = 1'b1;
        tick();
        check("halt_state", 32'(status[2:0]), 32'd5);
        tick();
        check("done_en",   32'(proc_en),        32'd0);
        check("done_halt", 32'(status[3]),      32'd1);
`ifdef PROC_LOAD_CTRL_CYCLE_CNT_EN
        check("done_ccnt", 32'(status[31:16]), 32'd10);
`else
        check("done_ccnt", 32'(status[31:16]), 32'd0);
`endif
        sw_cmd = 32'h8; proc_halt = 1'b0;
        tick();
        check("clr_done", 32'(status[2:0]), 32'd0);
        sw_cmd = 32'h0;
        tick();

        // Pause and single step.
        sw_cmd = 32'h2;
        tick();
        tick();
        sw_cmd = 32'h0;
        tick();
        check("pause_state", 32'(status[2:0]), 32'd3);
        tick();
        check("pause_en", 32'(proc_en), 32'd0);
        sw_cmd = 32'h4;
        tick();
        check("step_state", 32'(status[2:0]), 32'd4);
        tick();
        check("step_en_hi", 32'(proc_en),        32'd1);
        check("step_back",  32'(status[2:0]),    32'd3);
        tick();
        check("step_en_lo", 32'(proc_en), 32'd0);

        // clr and run rise together in PAUSE: clr wins.
        sw_cmd = 32'h0;
        tick();
        sw_cmd = 32'hA;
        tick();
        check("clr_win", 32'(status[2:0]), 32'd0);
        tick();
        check("clr_hold", 32'(proc_hold), 32'd1);

        // Reset in the middle of LOAD suppresses the pending write.
        sw_cmd = 32'h1;
        tick();
        sw_imem_addr = 32'd5; reset = 1'b0;
        tick();
        check("rst_abort_we", 32'(imem_we), 32'd0);
        reset = 1'b1; sw_cmd = 32'h0;
        tick();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            sw_cmd = {$urandom_range(0, 255) << 4} |
                     32'($urandom_range(0, 2) == 0) |
                     (32'($urandom_range(0, 1)) << 1) |
                     (32'($urandom_range(0, 3) == 0) << 2) |
                     (32'($urandom_range(0, 5) == 0) << 3);
            if ($urandom_range(0, 1) == 0) sw_imem_addr = $urandom_range(0, 3) | ($urandom_range(0, 1) << 20);
            sw_imem_data = $urandom;
            proc_halt = ($urandom_range(0, 7) == 0);
            tick();
        end

        // Write counter saturation.
        reset = 1'b0; proc_halt = 1'b0; sw_cmd = 32'h0;
        tick();
        reset = 1'b1; sw_cmd = 32'h1;
        tick();
        for (int i = 0; i < 4200; i++) begin
            sw_imem_addr = 32'(i & 1);
            sw_imem_data = 32'(i);
            tick();
        end
        check("wcnt_sat", 32'(status[15:4]), 32'hFFF);
        sw_cmd = 32'h0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
